// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer and the architecture table.
// Widths, dispatch/retire packets and the ROB entry layout.
package reorder_buffer_pkg;

  localparam int N_WAY            = 2;
  localparam int CDB_BITS         = 6;
  localparam int ROB_SIZE_DEFAULT = 32;

  typedef struct packed {
    logic                valid;
    logic [CDB_BITS-1:0] tag;
    logic [CDB_BITS-1:0] tag_old;
  } DISPATCH_ROB_PACKET;

  typedef struct packed {
    logic                valid;
    logic [CDB_BITS-1:0] tag;
    logic [CDB_BITS-1:0] tag_old;
  } RETIRE_ROB_PACKET;

  typedef struct packed {
    logic                valid;
    logic                complete;
    logic [CDB_BITS-1:0] tag;
    logic [CDB_BITS-1:0] tag_old;
  } ROB_ENTRY;

endpackage

// File: rtl/rob_retire_select.sv
// Head-window retire selection for the reorder buffer.
// Retires the longest run of valid+complete entries from the head.
module rob_retire_select
  import reorder_buffer_pkg::*;
#(
  parameter  int W  = N_WAY,
  localparam int RW = $clog2(W + 1)
) (
  input  logic [W-1:0]  win_valid_i,
  input  logic [W-1:0]  win_complete_i,
  input  logic          block_i,
  output logic [W-1:0]  ret_en_o,
  output logic [RW-1:0] ret_cnt_o
);

  logic run;

  // stop at the first empty or incomplete slot so retirement has no holes
  always_comb begin
    ret_en_o  = '0;
    ret_cnt_o = '0;
    run       = !block_i;
    for (int i = 0; i < W; i++) begin
      run         = run & win_valid_i[i] & win_complete_i[i];
      ret_en_o[i] = run;
      if (run) ret_cnt_o = ret_cnt_o + RW'(1);
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dispatch in, CDB completion CAM,
// up to N_WAY in-order retires per cycle to the architecture table.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE = ROB_SIZE_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  DISPATCH_ROB_PACKET dispatch_packet [N_WAY],
  input  logic               cdb_valid [N_WAY],
  input  logic [CDB_BITS-1:0] cdb_tag [N_WAY],
  input  logic               flush,
  output RETIRE_ROB_PACKET   ret_packet [N_WAY],
  output logic [$clog2(ROB_SIZE):0] free_count,
  output logic               rob_empty,
  output logic               rob_full
);

  localparam int PW = $clog2(ROB_SIZE);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(N_WAY + 1);

  ROB_ENTRY      rob_q [ROB_SIZE];
  ROB_ENTRY      rob_d [ROB_SIZE];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] free_q, free_d;

  logic [CW-1:0] disp_n;
  logic [CW-1:0] acc_n;
  logic          disp_ok;

  logic [PW-1:0] win_idx [N_WAY];
  logic [N_WAY-1:0] win_v;
  logic [N_WAY-1:0] win_c;
  logic [N_WAY-1:0] ret_en;
  logic [RW-1:0]    ret_cnt;

  // lanes are prefix-packed, so the valid count is the group size
  always_comb begin
    disp_n = '0;
    for (int i = 0; i < N_WAY; i++) begin
      if (dispatch_packet[i].valid) disp_n = disp_n + CW'(1);
    end
  end

  // whole group is taken only if it fits in the registered free count
  assign disp_ok = !flush && (disp_n <= free_q);
  assign acc_n   = disp_ok ? disp_n : '0;

  for (genvar i = 0; i < N_WAY; i++) begin : g_win
    assign win_idx[i] = head_q + PW'(i);
    assign win_v[i]   = rob_q[win_idx[i]].valid;
    assign win_c[i]   = rob_q[win_idx[i]].complete;
    assign ret_packet[i] = '{
      valid:   ret_en[i],
      tag:     rob_q[win_idx[i]].tag,
      tag_old: rob_q[win_idx[i]].tag_old
    };
  end

  rob_retire_select #(
    .W (N_WAY)
  ) u_sel (
    .win_valid_i    (win_v),
    .win_complete_i (win_c),
    .block_i        (flush),
    .ret_en_o       (ret_en),
    .ret_cnt_o      (ret_cnt)
  );

  // next state: CDB CAM, retire clear, dispatch write, then flush squash
  always_comb begin
    rob_d   = rob_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    free_d  = free_q;

    for (int e = 0; e < ROB_SIZE; e++) begin
      if (rob_q[e].valid && !rob_q[e].complete) begin
        for (int l = 0; l < N_WAY; l++) begin
          if (cdb_valid[l] && (cdb_tag[l] == rob_q[e].tag))
            rob_d[e].complete = 1'b1;
        end
      end
    end

    for (int i = 0; i < N_WAY; i++) begin
      if (ret_en[i]) begin
        rob_d[win_idx[i]].valid    = 1'b0;
        rob_d[win_idx[i]].complete = 1'b0;
      end
    end

    if (disp_ok) begin
      for (int i = 0; i < N_WAY; i++) begin
        if (dispatch_packet[i].valid) begin
          rob_d[tail_q + PW'(i)] = '{
            valid:    1'b1,
            complete: 1'b0,
            tag:      dispatch_packet[i].tag,
            tag_old:  dispatch_packet[i].tag_old
          };
        end
      end
    end

    head_d  = head_q + PW'(ret_cnt);
    tail_d  = tail_q + acc_n[PW-1:0];
    count_d = count_q + acc_n - CW'(ret_cnt);

    if (flush) begin
      for (int e = 0; e < ROB_SIZE; e++) rob_d[e] = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end

    free_d = CW'(ROB_SIZE) - count_d;
  end

  // state registers; reset matches the post-flush state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < ROB_SIZE; e++) rob_q[e] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      free_q  <= CW'(ROB_SIZE);
    end else begin
      rob_q   <= rob_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      free_q  <= free_d;
    end
  end

  assign free_count = free_q;
  assign rob_empty  = (count_q == '0);
  assign rob_full   = (count_q == CW'(ROB_SIZE));

  // an oversized dispatch group is an upstream protocol violation
  a_no_overflow: assert property (
    @(posedge clock) disable iff (reset)
    flush || (disp_n <= free_q)
  ) else $warning("reorder_buffer: dispatch group exceeds free entries, dropped");

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: stimulus pushes expected
// retires, a negedge monitor pops and compares them.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic                clock = 1'b0;
  logic                reset;
  DISPATCH_ROB_PACKET  dp [N_WAY];
  logic                cv [N_WAY];
  logic [CDB_BITS-1:0] ct [N_WAY];
  logic                flush;
  RETIRE_ROB_PACKET    rp [N_WAY];
  logic [5:0]          free_count;
  logic                rob_empty;
  logic                rob_full;

  int n_tests = 0;
  int n_fail  = 0;
  int m_cnt   = 0;
  RETIRE_ROB_PACKET exp_q [$];
  bit done [64];

  reorder_buffer #(.ROB_SIZE(32)) dut (
    .clock           (clock),
    .reset           (reset),
    .dispatch_packet (dp),
    .cdb_valid       (cv),
    .cdb_tag         (ct),
    .flush           (flush),
    .ret_packet      (rp),
    .free_count      (free_count),
    .rob_empty       (rob_empty),
    .rob_full        (rob_full)
  );

  always #5 clock = ~clock;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    for (int i = 0; i < N_WAY; i++) begin
      dp[i] = '0;
      cv[i] = 1'b0;
      ct[i] = '0;
    end
    flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic clear_model();
    exp_q.delete();
    foreach (done[i]) done[i] = 1'b0;
    m_cnt = 0;
  endtask

  task automatic set_disp(int n, int t0, int t1);
    int tg [N_WAY];
    RETIRE_ROB_PACKET e;
    tg[0] = t0;
    tg[1] = t1;
    for (int i = 0; i < n; i++) begin
      dp[i].valid   = 1'b1;
      dp[i].tag     = CDB_BITS'(tg[i]);
      dp[i].tag_old = CDB_BITS'(tg[i] ^ 21);
    end
    if (n <= 32 - m_cnt) begin
      for (int i = 0; i < n; i++) begin
        e.valid   = 1'b1;
        e.tag     = CDB_BITS'(tg[i]);
        e.tag_old = CDB_BITS'(tg[i] ^ 21);
        exp_q.push_back(e);
      end
      m_cnt += n;
    end
  endtask

  task automatic set_cdb(int n, int t0, int t1);
    int tg [N_WAY];
    tg[0] = t0;
    tg[1] = t1;
    for (int i = 0; i < n; i++) begin
      cv[i] = 1'b1;
      ct[i] = CDB_BITS'(tg[i]);
      done[tg[i]] = 1'b1;
    end
  endtask

  function automatic logic [1:0] rv();
    return {rp[1].valid, rp[0].valid};
  endfunction

  RETIRE_ROB_PACKET mon_e;
  logic             mon_prev;

  // monitor: every retiring lane must be the next program-order entry
  always @(negedge clock) begin
    mon_prev = 1'b1;
    for (int i = 0; i < N_WAY; i++) begin
      if (rp[i].valid) begin
        chk("ret_prefix", 32'(mon_prev), 32'd1);
        if (exp_q.size() == 0) begin
          chk("ret_unexpected", 32'(rp[i].tag), 32'hffff);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ret_tag", 32'(rp[i].tag), 32'(mon_e.tag));
          chk("ret_tag_old", 32'(rp[i].tag_old), 32'(mon_e.tag_old));
          chk("ret_done", 32'(done[mon_e.tag]), 32'd1);
          done[mon_e.tag] = 1'b0;
          m_cnt--;
        end
      end
      mon_prev = rp[i].valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    reset = 1'b1;
    clear_model();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 32'(rv()), 32'd0);
    chk("rst_free", 32'(free_count), 32'd32);
    chk("rst_empty", 32'(rob_empty), 32'd1);
    chk("rst_full", 32'(rob_full), 32'd0);
    reset = 1'b0;
    tick();

    // out-of-order completion
    set_disp(2, 33, 34); tick();
    set_cdb(1, 34, 0);   tick();
    chk("ooo_hold", 32'(rv()), 32'd0);
    set_cdb(1, 33, 0);   tick();
    chk("ooo_both", 32'(rv()), 32'd3);
    chk("ooo_lane0", 32'(rp[0].tag), 32'd33);
    chk("ooo_lane1", 32'(rp[1].tag), 32'd34);
    tick();
    chk("ooo_empty", 32'(rob_empty), 32'd1);

    // partial retire window
    set_disp(2, 1, 2); tick();
    set_disp(1, 3, 0); tick();
    set_cdb(2, 1, 3);  tick();
    chk("part_lane", 32'(rv()), 32'd1);
    chk("part_free", 32'(free_count), 32'd29);
    set_cdb(1, 2, 0);  tick();
    chk("part_rest", 32'(rv()), 32'd3);
    tick();
    chk("part_empty", 32'(rob_empty), 32'd1);

    // full boundary, group straddles the wrap point
    for (int k = 0; k < 16; k++) begin
      set_disp(2, 2 * k, 2 * k + 1);
      tick();
    end
    chk("full_flag", 32'(rob_full), 32'd1);
    chk("full_free", 32'(free_count), 32'd0);
    set_disp(2, 40, 41); tick();
    chk("full_drop", 32'(free_count), 32'd0);
    set_cdb(1, 0, 0);    tick();
    chk("full_ret1", 32'(rv()), 32'd1);
    chk("full_free_rt", 32'(free_count), 32'd0);
    set_disp(1, 42, 0);  tick();
    chk("full_free1", 32'(free_count), 32'd1);
    chk("full_unfull", 32'(rob_full), 32'd0);
    flush = 1'b1;
    clear_model();
    tick();

    // flush with completed head entries
    set_disp(2, 10, 11); tick();
    set_disp(2, 12, 13); tick();
    set_disp(2, 14, 15); tick();
    set_cdb(1, 12, 0);   tick();
    chk("fl_nohead", 32'(rv()), 32'd0);
    set_cdb(2, 10, 11);  tick();
    flush = 1'b1;
    #1;
    chk("fl_noret", 32'(rv()), 32'd0);
    clear_model();
    tick();
    chk("fl_empty", 32'(rob_empty), 32'd1);
    chk("fl_free", 32'(free_count), 32'd32);
    set_cdb(1, 13, 0);   tick();
    chk("fl_oldcdb", 32'(rv()), 32'd0);
    chk("fl_old_empty", 32'(rob_empty), 32'd1);
    clear_model();

    // walk head to 31, then wrap a 2-wide group across 31 -> 0
    for (int k = 0; k < 15; k++) begin
      set_disp(2, 2 * k, 2 * k + 1);
      tick();
    end
    set_disp(1, 30, 0); tick();
    for (int k = 0; k < 15; k++) begin
      set_cdb(2, 2 * k, 2 * k + 1);
      tick();
    end
    set_cdb(1, 30, 0); tick();
    repeat (3) tick();
    chk("wr_pre_empty", 32'(rob_empty), 32'd1);
    set_disp(2, 50, 51); tick();
    set_cdb(2, 50, 51);  tick();
    chk("wr_both", 32'(rv()), 32'd3);
    chk("wr_lane0", 32'(rp[0].tag), 32'd50);
    chk("wr_lane1", 32'(rp[1].tag), 32'd51);
    tick();
    chk("wr_empty", 32'(rob_empty), 32'd1);
    set_disp(2, 52, 53); tick();
    set_cdb(1, 52, 0);   tick();
    chk("wr_head1", 32'(rv()), 32'd1);
    chk("wr_head1_tag", 32'(rp[0].tag), 32'd52);
    set_cdb(1, 53, 0);   tick();
    tick();
    chk("wr_end_empty", 32'(rob_empty), 32'd1);

    // asynchronous reset mid-retire
    set_disp(2, 1, 2); tick();
    set_disp(2, 3, 4); tick();
    set_disp(1, 5, 0); tick();
    set_cdb(2, 1, 2);  tick();
    chk("ar_pre", 32'(rv()), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", 32'(rv()), 32'd0);
    chk("ar_free", 32'(free_count), 32'd32);
    chk("ar_empty", 32'(rob_empty), 32'd1);
    chk("ar_full", 32'(rob_full), 32'd0);
    clear_model();
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
    chk("ar_post", 32'(rv()), 32'd0);
    chk("ar_post_empty", 32'(rob_empty), 32'd1);

    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer feeding the architecture table. It accepts up to `N_WAY` renamed instructions per cycle from dispatch and marks them complete from CDB broadcasts. It emits up to `N_WAY` `RETIRE_ROB_PACKET`s per cycle, strictly in program order, on the port the architecture table consumes. It is the producing end of the retire interface.

## Interface
Parameters:
- `ROB_SIZE`, 32: entry count; must be a power of 2 and at least `2*N_WAY`.
- `N_WAY`, from the shared header: dispatch, CDB and retire width.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `dispatch_packet[N_WAY]` in `DISPATCH_ROB_PACKET`: fields `{valid, tag, tag_old}`; lanes are prefix-packed (lane k valid implies lanes 0..k-1 valid).
- `cdb_valid[N_WAY]` in 1: CDB broadcast valid per lane.
- `cdb_tag[N_WAY]` in `CDB_BITS`: completing physical tag.
- `flush` in 1: synchronous squash of all entries.
- `ret_packet[N_WAY]` out `RETIRE_ROB_PACKET`: `{valid, tag, tag_old}`; lane 0 is the oldest.
- `free_count` out `$clog2(ROB_SIZE)+1`: free entries, registered.
- `rob_empty` out 1; `rob_full` out 1.

## Operation
- Circular buffer with `head`/`tail` pointers of `$clog2(ROB_SIZE)` bits that wrap modulo `ROB_SIZE`, plus a registered `count`.
- Each entry holds `valid`, `complete`, `tag` and `tag_old`.
- **Dispatch:** let n be the number of valid lanes.
  - If `n <= free_count`: lane i writes entry `tail+i` with valid=1, complete=0. `tail` advances by n.
  - If `n > free_count`: this is an upstream protocol violation. Drop the whole group, leave state unchanged, and fire a simulation assertion.
- **Completion:** each CDB lane compares `cdb_tag` against every entry with valid=1 and complete=0, and sets `complete` on a match.
  - Several lanes may hit different entries in the same cycle.
  - A CDB tag matching no entry is ignored.
  - An entry dispatched in the same cycle does not observe that cycle's CDB.
- **Retire:** combinational from registered state.
  - Lane i is valid iff entries `head..head+i` are all valid and complete. Retirement stops at the first incomplete or empty entry, so there are no holes.
  - `ret_packet[i]` carries that entry's `tag` and `tag_old`.
  - At the edge, retired entries clear valid, and `head` advances by r (the number retired).
- **Count:** `count_next = count + n_accepted - r`. `free_count = ROB_SIZE - count`.
  - Slots retiring this cycle are not reusable by same-cycle dispatch; `free_count` is conservative.
- `rob_empty = (count == 0)`; `rob_full = (count == ROB_SIZE)`.
- **Flush** has priority over everything else:
  - During the flush cycle all `ret_packet` valid bits are forced to 0 and dispatch is ignored.
  - At the edge all entries are invalidated, `head = tail = count = 0`, and all complete bits are cleared.
- **Reset** (async, any time, including mid-retire): same state as flush.
  - Outputs immediately: all `ret_packet[i].valid = 0`, `free_count = ROB_SIZE`, `rob_empty = 1`, `rob_full = 0`.

## Timing
- Dispatch in cycle t: the entry is valid after edge t.
- CDB in cycle t: complete set at edge t. If the entry is at the head, `ret_packet` is valid in cycle t+1, and the architecture table updates at edge t+1.
- Minimum dispatch-to-retire latency: 2 cycles (dispatch t, CDB t+1, retire valid t+2).
- Sustained throughput: `N_WAY` retires per cycle.
- Wrap-around: a retire or dispatch group may straddle index `ROB_SIZE-1 -> 0`; pointer arithmetic is modulo.
- Full with simultaneous retire: dispatch is still refused that cycle because `free_count` = 0. Next cycle `free_count = r`.
- Empty with simultaneous dispatch: no same-cycle retire; the entries are incomplete at best.

## Structure
- Shared package/header holds:
  - `RETIRE_ROB_PACKET` (shared with the architecture table).
  - `DISPATCH_ROB_PACKET`.
  - The `ROB_ENTRY` struct.
  - `N_WAY`, `CDB_BITS` and the `ROB_SIZE` default.
- One sub-module, `rob_retire_select`: combinational. It takes the `N_WAY` head-window valid/complete bits and outputs the per-lane retire enables and the count r.
- Top level holds the storage, pointers, CDB CAM and count logic.

## Test plan
- **Reset mid-operation:** fill 5 entries, complete 2, assert `reset` asynchronously between edges. Required: `ret_packet` valid bits drop immediately; `free_count` = 32; `rob_empty` = 1.
- **Out-of-order completion:** dispatch tags 33, 34 (N_WAY=2), then CDB 34.
  - Required: no retire.
  - Then CDB 33: next cycle both lanes retire, lane0 tag 33 and lane1 tag 34; `head` += 2.
- **Full boundary:** dispatch 32 entries.
  - Required: `rob_full` = 1, `free_count` = 0.
  - A further 2-wide dispatch is dropped and the assertion fires.
  - Complete the head: retire 1; next cycle `free_count` = 1.
- **Wrap-around:** with `head` = 31 and 2 completed entries at indices 31 and 0, both retire in one cycle in order; `head` becomes 1.
- **Flush:** 6 entries, 3 completed at the head, assert `flush`.
  - Required: no `ret_packet` valid in that cycle.
  - Next cycle `rob_empty` = 1 and `free_count` = 32.
  - A CDB for an old tag afterwards has no effect.
- **Partial retire window:** head entry complete, head+1 incomplete, head+2 complete. Required: only lane0 valid; lane1 invalid.
